// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: front end of the MIPS-32 core.
//
// Holds the PC, fetches instruction words from instruction memory over a
// req/ack handshake, and presents each word together with its PC and opcode
// field to the decoder/datapath over a valid/ready handshake. Branch and jump
// redirects from downstream recompute the PC and squash any wrong-path fetch.
//
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_count / flush_count.
//
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   imem_req/addr     instruction memory request and byte address
//   imem_ack/rdata    memory response strobe and instruction word
//   instr_valid/ready downstream handshake for instr/instr_pc/opcode
//   instr, instr_pc   fetched instruction and its address
//   opcode            instr[31:26], always driven
//   redirect_branch   taken beq/bne, target = base+4 + sext(imm[15:0])<<2
//   redirect_jump     j, target = {base+4 [31:28], imm, 2'b00}; wins over branch
//   redirect_base_pc  PC of the redirecting instruction
//   redirect_imm      26-bit immediate field
//   fetch_count       (optional) accepted instructions
//   flush_count       (optional) redirects that squashed a fetch
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  input  logic        redirect_branch,
  input  logic        redirect_jump,
  input  logic [31:0] redirect_base_pc,
  input  logic [25:0] redirect_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  // Address of the in-flight request that must still be acked in DRAIN.
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        redirect;
  logic [31:0] base_plus4;
  logic [31:0] branch_off;
  logic [31:0] target;

  assign redirect   = redirect_branch | redirect_jump;
  assign base_plus4 = redirect_base_pc + 32'd4;
  assign branch_off = {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
  assign target     = redirect_jump ? {base_plus4[31:28], redirect_imm, 2'b00}
                                    : base_plus4 + branch_off;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    drain_addr_d = drain_addr_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect) pc_d = target;
      end
      StFetch: begin
        if (redirect) begin
          pc_d = target;
          if (imem_ack) begin
            // Wrong-path word arrives with the redirect: drop it, refetch.
            state_d = StFetch;
          end else begin
            // Request already issued; its ack must be absorbed first.
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = StValid;
        end
      end
      StValid: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StFetch;
        end else if (instr_ready) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (redirect) pc_d = target;
        if (imem_ack) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      instr_pc_q   <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = 32'h0;
    instr_valid = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      StValid: instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;
  assign opcode   = instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic        accept;
  logic        flush;
  logic [31:0] fetch_count_q, flush_count_q;

  // A redirect in VALID still honours a same-cycle handshake.
  assign accept = (state_q == StValid) && instr_ready;
  // Redirects in FETCH (ack or not) and VALID squash work; IDLE/DRAIN do not.
  assign flush  = redirect && ((state_q == StFetch) || (state_q == StValid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
      flush_count_q <= 32'h0;
    end else begin
      if (accept) fetch_count_q <= fetch_count_q + 32'd1;
      if (flush)  flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the MIPS-32 core.
- Holds the PC and requests instruction words from instruction memory over a req/ack handshake.
- Presents each fetched instruction, its PC and its opcode field to the main control decoder and datapath over a valid/ready handshake.
- Accepts branch and jump redirects from downstream, computes the target, and discards any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction memory request; held until imem_ack.
- imem_addr  output  32  byte address of request; stable while imem_req=1 and no ack.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instr/instr_pc/opcode valid.
- instr_ready  input  1  downstream accepts instruction.
- instr  output  32  instruction word.
- instr_pc  output  32  address of instr.
- opcode  output  6  instr[31:26], feeds control decoder.
- redirect_branch  input  1  taken beq/bne.
- redirect_jump  input  1  j.
- redirect_base_pc  input  32  PC of the branch/jump instruction.
- redirect_imm  input  26  jump target field; branch uses [15:0].

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, imem_req=0, imem_addr=0. Reset mid-transaction abandons it; a late imem_ack after reset is ignored (state IDLE).
- Target computation:
  - Jump: {base+4 [31:28], imm[25:0], 2'b00}.
  - Branch: base+4 + (sign_extend(imm[15:0]) << 2), modulo 2^32.
  - Jump wins when both redirect inputs are high.
- States IDLE, FETCH, VALID, DRAIN:
  - IDLE: outputs idle; next cycle -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, -> VALID.
  - VALID: instr_valid=1, imem_req=0.
    - On instr_ready: -> FETCH next cycle; instr_valid drops.
    - Outputs stable while instr_ready=0.
- Redirect (either redirect input high), highest priority over normal transitions:
  - IDLE: pc<=target, -> FETCH.
  - FETCH with imem_ack same cycle: data discarded, pc<=target, -> FETCH.
  - FETCH without ack: pc<=target, -> DRAIN.
  - DRAIN: imem_req=1 with the old address held; returned data discarded on ack, then -> FETCH. A further redirect in DRAIN overwrites pc (latest wins).
  - VALID: held instruction dropped (instr_valid=0 next cycle), pc<=target, -> FETCH. If instr_ready is high the same cycle, that handshake still counts as accepted.
- Latency:
  - Zero-wait memory: imem_req at cycle N, instr_valid at N+1.
  - Steady throughput: one instruction per 2 cycles.
- pc wraps from 32'hFFFF_FFFC to 0.
- opcode is always instr[31:26], including when instr_valid=0.

Optional Feature:
- FETCH_PERF_CNT_EN: adds outputs fetch_count[31:0] and flush_count[31:0].
  - Both reset to 0 and wrap.
  - fetch_count increments on each valid/ready handshake.
  - flush_count increments on each redirect that discards a held instruction, an acked wrong-path word, or enters DRAIN.
- Without the macro, the ports and counters are absent.

Test Plan:
- Reset release with RESET_PC=0, memory acks next cycle returning 32'h8C08_0004 -> imem_addr 0; instr_valid=1 with instr=8C08_0004, opcode=6'b100011, instr_pc=0; next request at addr 4.
- instr_ready held low 5 cycles in VALID -> instr/instr_pc stable, imem_req=0; release -> next fetch at pc+4.
- Branch redirect while VALID: base=0x10, imm=16'hFFFE -> next imem_addr=0x0C; old instr never accepted.
- Jump redirect while FETCH, ack delayed 3 cycles: base=0x4000_0000, imm=26'h0000100 -> old address held through DRAIN, its data discarded; next imem_addr=0x4000_0400.
- Both redirect inputs high: base=0x20, imm=26'h10 -> jump target 0x40 used.
- Assert reset during DRAIN with late ack -> all outputs 0, ack ignored, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
